wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
  clock  in  1  rising-edge clock
  reset_n  in  1  asynchronous, active-low reset
  redirect_flush  in  1  synchronous flush; discards all queued entries
  in_valid  in  1  upstream pipeline-register instr_valid
  in_ready  out  1  drives upstream out_ready; queue can accept
  in_need_to_wb  in  1  entry writes a physical register
  in_prd  in  PREG_W  destination physical register
  in_pc  in  PC_W  instruction PC
  in_is_load  in  1  select load data
  in_is_muldiv  in  1  select muldiv result (muldiv_type nonzero)
  in_is_bju  in  1  select bju result (cx_type nonzero)
  in_alu_result / in_bju_result / in_muldiv_result / in_load_data  in  RESULT_W each  candidate results
  wb_valid  out  1  head entry presented to regfile/commit port
  wb_ready  in  1  port accepts head this cycle
  wb_wen  out  1  regfile write enable (head handshake AND head need_to_wb)
  wb_prd  out  PREG_W  head destination register
  wb_data  out  RESULT_W  head selected result
  wb_pc  out  PC_W  head PC
  occupancy  out  2  entries held (0..2)

Function
REQ-002 Storage SHALL be a 2-entry FIFO; each entry holds {need_to_wb, prd, data, pc}.
REQ-003 Result selection SHALL occur at enqueue with priority load > muldiv > bju > alu.
REQ-004 Enqueue fire SHALL be in_valid & in_ready; dequeue fire SHALL be wb_valid & wb_ready.
REQ-005 in_ready SHALL be (occupancy < 2), computed from registered state only; no same-cycle pass-through of dequeue into in_ready.
REQ-006 wb_valid SHALL be (occupancy != 0); wb_prd/wb_data/wb_pc SHALL come from the head entry.
REQ-007 An entry enqueued in cycle N SHALL appear on wb_valid in cycle N+1 at the earliest (1-cycle latency, no bypass).
REQ-008 wb_wen SHALL be wb_valid & wb_ready & head.need_to_wb; an entry with need_to_wb=0 SHALL still dequeue normally.
REQ-009 Simultaneous enqueue and dequeue with occupancy 1 SHALL leave occupancy 1 and keep order.
REQ-010 Head/tail pointers SHALL be 1 bit each and wrap 1->0; order SHALL be strict FIFO.
REQ-011 With occupancy 2, in_valid SHALL be ignored (in_ready=0) even if a dequeue fires that cycle.
REQ-012 wb_valid SHALL stay asserted with stable head fields until dequeued or flushed.
REQ-013 redirect_flush SHALL take priority over same-cycle enqueue: next cycle occupancy=0, pointers=0, wb_valid=0; a same-cycle dequeue handshake SHALL still count as delivered (wb_wen unaffected that cycle).
REQ-014 Flush while empty SHALL have no visible effect beyond holding state at reset values.

Reset
REQ-015 On reset_n low (asynchronous) occupancy, pointers, and all entry valid state SHALL clear; wb_valid=0, wb_wen=0, in_ready=1 after release.
REQ-016 Entry data fields SHALL reset to 0 so wb_prd/wb_data/wb_pc read 0 while empty after reset.
REQ-017 Reset asserted mid-operation SHALL drop all entries without producing any wb_wen.

Structure
REQ-018 PREG_W (6), PC_W (64), RESULT_W (64) and the entry record type SHALL live in the shared core package/defines.
REQ-019 Result selection SHALL be a sub-module wb_result_sel (combinational, 4:1 priority mux); all state SHALL be in wb_queue.

Verification
REQ-020 Reset release -> in_ready=1, wb_valid=0, occupancy=0, wb_prd=0, wb_data=0.
REQ-021 Enqueue alu=0x11, prd=5, need_to_wb=1, wb_ready=1 -> next cycle wb_valid=1, wb_wen=1, wb_prd=5, wb_data=0x11; following cycle occupancy=0.
REQ-022 wb_ready=0, enqueue three back-to-back (pc 0x100,0x104,0x108) -> occupancy=2, in_ready=0, third not taken; raise wb_ready -> 0x100 then 0x104 in order.
REQ-023 Enqueue with in_is_load=1 and in_is_muldiv=1, load_data=0xAA, muldiv=0xBB -> wb_data=0xAA; need_to_wb=0 entry -> wb_valid=1, wb_wen=0, still dequeues.
REQ-024 Occupancy 2, assert redirect_flush with in_valid=1 -> next cycle occupancy=0, wb_valid=0, no wb_wen; new enqueue the cycle after is accepted normally.
REQ-025 Occupancy 1, simultaneous enqueue and dequeue for 10 cycles -> occupancy stays 1, output PCs match input order with 1-cycle lag.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// Shared widths and the writeback queue entry record.
package wb_queue_pkg;
  localparam int PREG_W   = 6;
  localparam int PC_W     = 64;
  localparam int RESULT_W = 64;
  localparam int QDEPTH   = 2;

  typedef struct packed {
    logic                need_to_wb;
    logic [PREG_W-1:0]   prd;
    logic [RESULT_W-1:0] data;
    logic [PC_W-1:0]     pc;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// Upstream enqueue side and regfile/commit side of the writeback queue.
interface wb_queue_if;
  import wb_queue_pkg::*;

  logic                redirect_flush;
  logic                in_valid;
  logic                in_ready;
  logic                in_need_to_wb;
  logic [PREG_W-1:0]   in_prd;
  logic [PC_W-1:0]     in_pc;
  logic                in_is_load;
  logic                in_is_muldiv;
  logic                in_is_bju;
  logic [RESULT_W-1:0] in_alu_result;
  logic [RESULT_W-1:0] in_bju_result;
  logic [RESULT_W-1:0] in_muldiv_result;
  logic [RESULT_W-1:0] in_load_data;
  logic                wb_valid;
  logic                wb_ready;
  logic                wb_wen;
  logic [PREG_W-1:0]   wb_prd;
  logic [RESULT_W-1:0] wb_data;
  logic [PC_W-1:0]     wb_pc;
  logic [1:0]          occupancy;

  modport slave (
    input  redirect_flush, in_valid, in_need_to_wb, in_prd, in_pc,
           in_is_load, in_is_muldiv, in_is_bju,
           in_alu_result, in_bju_result, in_muldiv_result, in_load_data,
           wb_ready,
    output in_ready, wb_valid, wb_wen, wb_prd, wb_data, wb_pc, occupancy
  );

  modport master (
    output redirect_flush, in_valid, in_need_to_wb, in_prd, in_pc,
           in_is_load, in_is_muldiv, in_is_bju,
           in_alu_result, in_bju_result, in_muldiv_result, in_load_data,
           wb_ready,
    input  in_ready, wb_valid, wb_wen, wb_prd, wb_data, wb_pc, occupancy
  );
endinterface

// File: rtl/wb_result_sel.sv
// Picks the writeback result at enqueue: load > muldiv > bju > alu.
module wb_result_sel
  import wb_queue_pkg::*;
(
  input  logic                is_load,
  input  logic                is_muldiv,
  input  logic                is_bju,
  input  logic [RESULT_W-1:0] alu_result,
  input  logic [RESULT_W-1:0] bju_result,
  input  logic [RESULT_W-1:0] muldiv_result,
  input  logic [RESULT_W-1:0] load_data,
  output logic [RESULT_W-1:0] data
);
  always_comb begin
    data = alu_result;
    if (is_load)        data = load_data;
    else if (is_muldiv) data = muldiv_result;
    else if (is_bju)    data = bju_result;
  end
endmodule

// File: rtl/wb_queue.sv
// Two-entry writeback FIFO between the execute pipeline register and the
// regfile/commit port; result is selected on the way in, no bypass.
module wb_queue
  import wb_queue_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  wb_queue_if.slave   q
);
  wb_entry_t           entry_q [QDEPTH];
  logic                head_q, tail_q;
  logic [1:0]          count_q;
  logic [RESULT_W-1:0] sel_data;
  logic                enq_fire, deq_fire;
  wb_entry_t           head;

  wb_result_sel u_sel (
    .is_load       (q.in_is_load),
    .is_muldiv     (q.in_is_muldiv),
    .is_bju        (q.in_is_bju),
    .alu_result    (q.in_alu_result),
    .bju_result    (q.in_bju_result),
    .muldiv_result (q.in_muldiv_result),
    .load_data     (q.in_load_data),
    .data          (sel_data)
  );

  // in_ready looks only at registered occupancy so a full queue never
  // accepts on the strength of a same-cycle dequeue.
  assign q.in_ready  = (count_q < 2'd2);
  assign q.wb_valid  = (count_q != 2'd0);
  assign q.occupancy = count_q;

  assign enq_fire = q.in_valid & q.in_ready;
  assign deq_fire = q.wb_valid & q.wb_ready;

  assign head     = entry_q[head_q];
  assign q.wb_prd  = head.prd;
  assign q.wb_data = head.data;
  assign q.wb_pc   = head.pc;
  assign q.wb_wen  = deq_fire & head.need_to_wb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) entry_q[i] <= '0;
    end else if (q.redirect_flush) begin
      // Flush beats enqueue; any dequeue this cycle was already delivered.
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (enq_fire) begin
        entry_q[tail_q] <= '{need_to_wb: q.in_need_to_wb, prd: q.in_prd,
                             data: sel_data, pc: q.in_pc};
        tail_q <= ~tail_q;
      end
      if (deq_fire) head_q <= ~head_q;
      count_q <= count_q + {1'b0, enq_fire} - {1'b0, deq_fire};
    end
  end
endmodule
